data_bus_ram_responder: RTL and testbench

DATA_BUS_RAM_RESPONDER -- requirements
Module: data_bus_ram_responder

---
 rtl/data_bus_ram_responder.sv | 90 +++++++++
 tb/tb_data_bus_ram_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/data_bus_ram_responder.sv
// rtl/data_bus_ram_responder.sv - word RAM slave on a shared tri-state data bus
// Self-clears after reset, then serves aligned reads/writes and flags misaligned or reserved accesses.
module data_bus_ram_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire  [31:0] data_bus_data,
  input  logic [31:0] data_bus_addr,
  input  logic [1:0]  data_bus_mode,
  output logic        init_busy,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [15:0] read_count,
  output logic [15:0] write_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {INIT, READY} state_t;

  state_t                state, state_next;
  logic [DEPTH_LOG2-1:0] index;
  logic [31:0]           mem [DEPTH];

  logic                  selected, aligned, active;
  logic [DEPTH_LOG2-1:0] word;
  logic                  rd_hit, wr_hit, fault_hit;

  assign selected = (data_bus_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
  assign word     = data_bus_addr[DEPTH_LOG2+1:2];
  assign aligned  = (data_bus_addr[1:0] == 2'b00);
  // Gate on reset too, so a pending reset keeps the bus quiet before the edge.
  assign active   = (state == READY) && !reset && selected;

  assign rd_hit    = active && aligned && (data_bus_mode == 2'b01);
  assign wr_hit    = active && aligned && (data_bus_mode == 2'b10);
  assign fault_hit = active && ((data_bus_mode == 2'b11) ||
                     (!aligned && (data_bus_mode == 2'b01 || data_bus_mode == 2'b10)));

  assign data_bus_data = rd_hit ? mem[word] : 32'bz;

  always_comb begin
    state_next = state;
    init_busy  = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        if (index == '1) state_next = READY;
      end
      READY: state_next = READY;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      index <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) index <= index + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) mem[index] <= '0;
      else if (wr_hit)   mem[word]  <= data_bus_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault       <= 1'b0;
      fault_addr  <= '0;
      read_count  <= '0;
      write_count <= '0;
    end else begin
      if (fault_hit) begin
        fault <= 1'b1;
        if (!fault) fault_addr <= data_bus_addr;
      end
      if (rd_hit && read_count != 16'hFFFF)  read_count  <= read_count + 1'b1;
      if (wr_hit && write_count != 16'hFFFF) write_count <= write_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_data_bus_ram_responder.sv
// tb/tb_data_bus_ram_responder.sv - directed self-checking bench for data_bus_ram_responder
// The bus is pulled up, so an undriven bus reads as all ones.
module tb_data_bus_ram_responder;

  logic        clk = 1'b0;
  logic        reset;
  tri1  [31:0] data_bus_data;
  logic [31:0] data_bus_addr;
  logic [1:0]  data_bus_mode;
  logic        init_busy, fault;
  logic [31:0] fault_addr;
  logic [15:0] read_count, write_count;

  logic        drv_en;
  logic [31:0] drv_data;
  int          checks = 0;
  int          failures = 0;
  int          n;

  localparam logic [31:0] FLOAT = 32'hFFFF_FFFF;

  assign data_bus_data = drv_en ? drv_data : 32'bz;

  always #5 clk = ~clk;

  data_bus_ram_responder #(.BASE_ADDR(32'h0000_1000), .DEPTH_LOG2(8)) dut (
    .clk(clk), .reset(reset), .data_bus_data(data_bus_data),
    .data_bus_addr(data_bus_addr), .data_bus_mode(data_bus_mode),
    .init_busy(init_busy), .fault(fault), .fault_addr(fault_addr),
    .read_count(read_count), .write_count(write_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [1:0] mode, input logic [31:0] addr,
                     input logic en, input logic [31:0] data);
    data_bus_mode = mode;
    data_bus_addr = addr;
    drv_en        = en;
    drv_data      = data;
  endtask

  task automatic idle();
    bus(2'b00, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus(2'b01, addr, 1'b0, 32'h0);
    @(negedge clk);
    chk(tag, data_bus_data, exp);
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    cyc();
    chk("rst_init_busy", {31'b0, init_busy}, 32'd1);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    chk("rst_counts", {read_count, write_count}, 32'h0);
    chk("rst_bus_float", data_bus_data, FLOAT);
    reset = 1'b0;

    // Count INIT cycles; inject a write on INIT cycle 10 that must be ignored.
    n = 0;
    while (init_busy && n < 1000) begin
      if (n == 10) bus(2'b10, 32'h1000, 1'b1, 32'h55);
      else idle();
      cyc();
      n++;
    end
    idle();
    chk("init_len", n, 32'd256);
    chk("init_busy_low", {31'b0, init_busy}, 32'd0);
    chk("init_wr_ignored_cnt", {16'h0, write_count}, 32'd0);

    read_chk("rd_cleared_10fc", 32'h10FC, 32'h0);
    read_chk("rd_init_wr_1000", 32'h1000, 32'h0);

    bus(2'b10, 32'h1010, 1'b1, 32'hDEAD_BEEF); cyc();
    idle(); cyc();
    read_chk("rd_deadbeef", 32'h1010, 32'hDEAD_BEEF);
    chk("cnt_after_rw", {read_count, write_count}, {16'd3, 16'd1});

    bus(2'b10, 32'h13FC, 1'b1, 32'h1234_5678); cyc();
    read_chk("rd_after_wr_b2b", 32'h13FC, 32'h1234_5678);

    read_chk("rd_unsel_2000", 32'h2000, FLOAT);
    bus(2'b10, 32'h0FFC, 1'b1, 32'hCAFE_0000); cyc();
    idle();
    chk("unsel_no_fault", {31'b0, fault}, 32'd0);
    chk("unsel_counts", {read_count, write_count}, {16'd4, 16'd2});
    read_chk("rd_last_word_kept", 32'h13FC, 32'h1234_5678);
    read_chk("rd_unsel_1400", 32'h1400, FLOAT);

    bus(2'b10, 32'h1002, 1'b1, 32'h9999_9999); cyc();
    idle();
    chk("mis_wr_fault", {31'b0, fault}, 32'd1);
    chk("mis_wr_fault_addr", fault_addr, 32'h1002);
    read_chk("mis_rd_float", 32'h1005, FLOAT);
    bus(2'b11, 32'h1010, 1'b0, 32'h0);
    @(negedge clk);
    chk("mode11_float", data_bus_data, FLOAT);
    cyc();
    idle();
    chk("first_fault_wins", fault_addr, 32'h1002);
    chk("fault_counts", {read_count, write_count}, {16'd5, 16'd2});
    read_chk("mis_wr_no_change", 32'h1000, 32'h0);
    read_chk("mode11_no_change", 32'h1010, 32'hDEAD_BEEF);
    chk("counts_before_hold", {read_count, write_count}, {16'd7, 16'd2});

    bus(2'b01, 32'h1000, 1'b0, 32'h0);
    repeat (70000) cyc();
    chk("read_count_sat", {16'h0, read_count}, 32'h0000_FFFF);
    chk("write_count_hold", {16'h0, write_count}, 32'd2);

    reset = 1'b1;
    @(negedge clk);
    chk("rst_high_float", data_bus_data, FLOAT);
    cyc();
    chk("rst2_read_count", {16'h0, read_count}, 32'h0);
    chk("rst2_init_busy", {31'b0, init_busy}, 32'd1);
    chk("rst2_fault", {fault, fault_addr[30:0]}, 32'h0);
    reset = 1'b0;
    idle();
    n = 0;
    while (init_busy && n < 1000) begin
      cyc();
      n++;
    end
    chk("init2_len", n, 32'd256);
    read_chk("rd_recleared_1010", 32'h1010, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
